// File: rtl/immencoder_pkg.sv
// Shared definitions for the immediate encoder: type-select bit indices,
// immediate field positions in the instruction word, and the default value width.
package immencoder_pkg;

  localparam int XLEN_DEF = 64;

  localparam int TYPE_W  = 5;
  localparam int TYPE_I  = 0;
  localparam int TYPE_S  = 1;
  localparam int TYPE_SB = 2;
  localparam int TYPE_U  = 3;
  localparam int TYPE_UJ = 4;

  localparam int I_IMM_LSB = 20;
  localparam int S_HI_LSB  = 25;
  localparam int S_LO_LSB  = 7;
  localparam int SB_LO_LSB = 8;
  localparam int U_IMM_LSB = 12;
  localparam int UJ_HI_LSB = 21;

  typedef logic [TYPE_W-1:0] type_sel_t;

  // True when more than one select bit is set (clearing the lowest set bit leaves something).
  function automatic logic multi_hot(input type_sel_t sel);
    return (sel & (sel - TYPE_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/immencoder_imm_scatter.sv
// Combinational scatter of a sign-extended value into the immediate fields of an
// instruction template, with representability and type-select checks.
module imm_scatter
  import immencoder_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]     tmpl,
  input  type_sel_t       types,
  input  logic [XLEN-1:0] value,
  output logic [31:0]     instr,
  output logic            range_err,
  output logic            type_err
);

  logic same_11;
  logic same_12;
  logic same_20;
  logic same_31;

  // Upper bits all equal means the value fits the field as a signed quantity.
  assign same_11 = (&value[XLEN-1:11]) | ~(|value[XLEN-1:11]);
  assign same_12 = (&value[XLEN-1:12]) | ~(|value[XLEN-1:12]);
  assign same_20 = (&value[XLEN-1:20]) | ~(|value[XLEN-1:20]);
  assign same_31 = (&value[XLEN-1:31]) | ~(|value[XLEN-1:31]);

  assign type_err = multi_hot(types);

  always_comb begin
    instr     = tmpl;
    range_err = 1'b0;
    if (!type_err) begin
      if (types[TYPE_I]) begin
        instr[I_IMM_LSB +: 12] = value[11:0];
        range_err              = ~same_11;
      end else if (types[TYPE_S]) begin
        instr[S_HI_LSB +: 7] = value[11:5];
        instr[S_LO_LSB +: 5] = value[4:0];
        range_err            = ~same_11;
      end else if (types[TYPE_SB]) begin
        instr[31]             = value[12];
        instr[7]              = value[11];
        instr[S_HI_LSB +: 6]  = value[10:5];
        instr[SB_LO_LSB +: 4] = value[4:1];
        range_err             = ~same_12 | value[0];
      end else if (types[TYPE_U]) begin
        instr[U_IMM_LSB +: 20] = value[31:12];
        range_err              = ~same_31 | (|value[11:0]);
      end else if (types[TYPE_UJ]) begin
        instr[31]              = value[20];
        instr[U_IMM_LSB +: 8]  = value[19:12];
        instr[20]              = value[11];
        instr[UJ_HI_LSB +: 10] = value[10:1];
        range_err              = ~same_20 | value[0];
      end
    end
  end

endmodule

// File: rtl/immencoder.sv
// Two-stage valid/ready immediate encoder: S1 holds the request, S2 holds the
// scattered instruction and error flags. Full backpressure, no skid buffer.
module immencoder
  import immencoder_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     template_i,
  input  logic            typeI_i,
  input  logic            typeS_i,
  input  logic            typeSB_i,
  input  logic            typeU_i,
  input  logic            typeUJ_i,
  input  logic [XLEN-1:0] value_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [31:0]     instruction_o,
  output logic            range_err_o,
  output logic            type_err_o
);

  logic            s1_valid;
  logic            s1_load;
  logic            s2_load;
  logic [31:0]     s1_tmpl;
  type_sel_t       s1_types;
  logic [XLEN-1:0] s1_value;
  type_sel_t       in_types;

  logic [31:0]     scat_instr;
  logic            scat_range_err;
  logic            scat_type_err;

  always_comb begin
    in_types          = '0;
    in_types[TYPE_I]  = typeI_i;
    in_types[TYPE_S]  = typeS_i;
    in_types[TYPE_SB] = typeSB_i;
    in_types[TYPE_U]  = typeU_i;
    in_types[TYPE_UJ] = typeUJ_i;
  end

  assign s2_load = ~valid_o | ready_i;
  assign s1_load = ~s1_valid | s2_load;
  assign ready_o = s1_load;

  // Output registers are reset so they read zero until the first result lands.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_valid      <= 1'b0;
      valid_o       <= 1'b0;
      instruction_o <= '0;
      range_err_o   <= 1'b0;
      type_err_o    <= 1'b0;
    end else begin
      if (s1_load) s1_valid <= valid_i;
      if (s2_load) begin
        valid_o <= s1_valid;
        if (s1_valid) begin
          instruction_o <= scat_instr;
          range_err_o   <= scat_range_err;
          type_err_o    <= scat_type_err;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (s1_load && valid_i) begin
      s1_tmpl  <= template_i;
      s1_types <= in_types;
      s1_value <= value_i;
    end
  end

  imm_scatter #(.XLEN(XLEN)) u_scatter (
    .tmpl      (s1_tmpl),
    .types     (s1_types),
    .value     (s1_value),
    .instr     (scat_instr),
    .range_err (scat_range_err),
    .type_err  (scat_type_err)
  );

endmodule

// File: tb/tb_immencoder.sv
// Scoreboard bench for immencoder: directed cases, backpressure, async reset,
// then randomized traffic checked against a bit-mapping reference model.
module tb_immencoder;

  localparam int XLEN = 64;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            valid_i;
  logic            ready_o;
  logic [31:0]     template_i;
  logic            typeI_i, typeS_i, typeSB_i, typeU_i, typeUJ_i;
  logic [XLEN-1:0] value_i;
  logic            valid_o;
  logic            ready_i;
  logic [31:0]     instruction_o;
  logic            range_err_o;
  logic            type_err_o;

  immencoder #(.XLEN(XLEN)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .template_i    (template_i),
    .typeI_i       (typeI_i),
    .typeS_i       (typeS_i),
    .typeSB_i      (typeSB_i),
    .typeU_i       (typeU_i),
    .typeUJ_i      (typeUJ_i),
    .value_i       (value_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .instruction_o (instruction_o),
    .range_err_o   (range_err_o),
    .type_err_o    (type_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] instr;
    logic        rerr;
    logic        terr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rand_ready = 1'b0;

  localparam logic [4:0] T_NONE = 5'b00000;
  localparam logic [4:0] T_I    = 5'b00001;
  localparam logic [4:0] T_S    = 5'b00010;
  localparam logic [4:0] T_SB   = 5'b00100;
  localparam logic [4:0] T_U    = 5'b01000;
  localparam logic [4:0] T_UJ   = 5'b10000;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Reference: signed-range arithmetic plus explicit bit-by-bit field placement.
  function automatic exp_t model(input logic [31:0] t, input logic [4:0] ty, input logic [63:0] v);
    exp_t   e;
    longint sv;
    sv     = $signed(v);
    e      = '0;
    e.instr = t;
    if ($countones(ty) > 1) begin
      e.terr = 1'b1;
    end else if (ty == T_I) begin
      for (int k = 0; k < 12; k++) e.instr[20 + k] = v[k];
      e.rerr = !(sv >= -2048 && sv <= 2047);
    end else if (ty == T_S) begin
      for (int k = 0; k < 5; k++)  e.instr[7 + k] = v[k];
      for (int k = 5; k < 12; k++) e.instr[20 + k] = v[k];
      e.rerr = !(sv >= -2048 && sv <= 2047);
    end else if (ty == T_SB) begin
      e.instr[31] = v[12];
      e.instr[7]  = v[11];
      for (int k = 5; k < 11; k++) e.instr[20 + k] = v[k];
      for (int k = 1; k < 5; k++)  e.instr[7 + k] = v[k];
      e.rerr = !(sv >= -4096 && sv <= 4095) || (sv % 2 != 0);
    end else if (ty == T_U) begin
      for (int k = 12; k < 32; k++) e.instr[k] = v[k];
      e.rerr = !(sv >= -64'sd2147483648 && sv <= 64'sd2147483647) || (sv % 4096 != 0);
    end else if (ty == T_UJ) begin
      e.instr[31] = v[20];
      e.instr[20] = v[11];
      for (int k = 12; k < 20; k++) e.instr[k] = v[k];
      for (int k = 1; k < 11; k++)  e.instr[20 + k] = v[k];
      e.rerr = !(sv >= -1048576 && sv <= 1048575) || (sv % 2 != 0);
    end
    return e;
  endfunction

  // Monitor: every consumed result must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (!reset_i && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h, expected no output", instruction_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("instruction", {32'h0, instruction_o}, {32'h0, e.instr});
        check("range_err", {63'h0, range_err_o}, {63'h0, e.rerr});
        check("type_err", {63'h0, type_err_o}, {63'h0, e.terr});
      end
    end
  end

  task automatic set_req(input logic [31:0] t, input logic [4:0] ty, input logic [63:0] v);
    template_i = t;
    {typeUJ_i, typeU_i, typeSB_i, typeS_i, typeI_i} = ty;
    value_i = v;
    valid_i = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [31:0] t, input logic [4:0] ty, input logic [63:0] v);
    int waited = 0;
    set_req(t, ty, v);
    if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
    @(negedge clk_i);
    while (!ready_o && waited < 50) begin
      @(posedge clk_i);
      #1;
      if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk_i);
      waited++;
    end
    if (!ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got ready_o=0 for %0d cycles, expected acceptance", waited);
    end else begin
      sb.push_back(model(t, ty, v));
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    ready_i = 1'b1;
    while (sb.size() != 0 && w < 200) begin
      @(posedge clk_i);
      w++;
    end
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [63:0] edges [16] = '{
    64'd2047, 64'd2048, -64'd2048, -64'd2049, 64'd4095, 64'd4094, 64'd4096, -64'd4096,
    -64'd4098, 64'd1048574, 64'd1048576, -64'd1048576, -64'd1048578,
    64'h7FFFF000, 64'h80000000, 64'hFFFF_FFFF_8000_0000
  };

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [4:0]  ty;
    logic [63:0] v;
    logic [31:0] r;
    int a, b;

    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    set_req(32'h0, T_NONE, 64'h0);
    valid_i = 1'b0;
    #12;
    check("reset_valid_o", {63'h0, valid_o}, 64'd0);
    check("reset_ready_o", {63'h0, ready_o}, 64'd1);
    check("reset_instr", {32'h0, instruction_o}, 64'd0);
    check("reset_errs", {62'h0, range_err_o, type_err_o}, 64'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // Latency: request presented, captured on the next edge, visible one edge later.
    issue(32'h00000013, T_I, -64'd1);
    check("latency_early", {63'h0, valid_o}, 64'd0);
    @(posedge clk_i);
    #1;
    check("latency_valid", {63'h0, valid_o}, 64'd1);
    check("addi_instr", {32'h0, instruction_o}, 64'h00000000FFF00013);
    drain();

    issue(32'h00000063, T_SB, -64'd2);
    issue(32'h00000063, T_SB, 64'd4096);
    issue(32'h00000063, T_SB, 64'd3);
    issue(32'h00000037, T_U, 64'h12345000);
    issue(32'h00000037, T_U, 64'h80000000);
    issue(32'h0000006F, T_UJ, 64'd2048);
    issue(32'h00A53423, T_S, -64'd24);
    issue(32'h12345678, T_I | T_S, 64'd5);
    issue(32'h87654321, T_NONE, 64'hDEAD);
    drain();

    // Backpressure: two requests fill the pipe, the third stalls until release.
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    set_req(32'h00000013, T_I, 64'd1);
    @(negedge clk_i);
    check("bp_accept_a", {63'h0, ready_o}, 64'd1);
    sb.push_back(model(32'h00000013, T_I, 64'd1));
    @(posedge clk_i);
    #1;
    set_req(32'h00000013, T_I, 64'd2);
    @(negedge clk_i);
    check("bp_accept_b", {63'h0, ready_o}, 64'd1);
    sb.push_back(model(32'h00000013, T_I, 64'd2));
    @(posedge clk_i);
    #1;
    set_req(32'h00000013, T_I, 64'd3);
    @(negedge clk_i);
    check("bp_stall_c", {63'h0, ready_o}, 64'd0);
    check("bp_valid_held", {63'h0, valid_o}, 64'd1);
    check("bp_instr_held", {32'h0, instruction_o}, {32'h0, sb[0].instr});
    @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_accept_c", {63'h0, ready_o}, 64'd1);
    sb.push_back(model(32'h00000013, T_I, 64'd3));
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    drain();

    // Async reset with both stages full: outputs drop before any clock edge.
    ready_i = 1'b0;
    issue(32'h00000013, T_I, 64'd7);
    issue(32'h00000013, T_I, 64'd8);
    #2;
    reset_i = 1'b1;
    #1;
    check("async_rst_valid_o", {63'h0, valid_o}, 64'd0);
    check("async_rst_ready_o", {63'h0, ready_o}, 64'd1);
    sb.delete();
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_rst_idle", {63'h0, valid_o}, 64'd0);

    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0: ty = T_NONE;
        1: begin
          a  = $urandom_range(0, 4);
          b  = (a + $urandom_range(1, 4)) % 5;
          ty = 5'(1 << a) | 5'(1 << b);
        end
        default: ty = 5'(1 << $urandom_range(0, 4));
      endcase
      r = $urandom;
      case ($urandom_range(0, 5))
        0: v = 64'($signed(33'($urandom_range(0, 10000)) - 33'sd5000));
        1: v = edges[$urandom_range(0, 15)];
        2: v = {$urandom, $urandom};
        3: v = {{32{r[31]}}, r[31:12], 12'h000};
        4: v = 64'($signed(33'($urandom_range(0, 4200000)) - 33'sd2100000));
        default: v = {{44{r[19]}}, r[19:0]};
      endcase
      issue($urandom, ty, v);
    end
    rand_ready = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
